// File: rtl/approx_adder_if.sv
// Stimulus/response link between the error monitor and the approximate adder it evaluates.
interface approx_adder_if #(
    parameter int unsigned IN_W  = 2,
    parameter int unsigned OUT_W = IN_W + 1
);
    logic              stim_valid;
    logic [2*IN_W-1:0] stim_data;
    logic              resp_valid;
    logic [OUT_W-1:0]  resp_data;

    modport master (output stim_valid, output stim_data, input resp_valid, input resp_data);
    modport slave  (input stim_valid, input stim_data, output resp_valid, output resp_data);
endinterface

// File: rtl/approx_adder_error_monitor.sv
// Exhaustive sweep harness: drives every operand pair into an approximate adder,
// accumulates error statistics against the exact sum and reports pass/fail against ET.
module approx_adder_error_monitor #(
    parameter int unsigned IN_W    = 2,
    parameter int unsigned OUT_W   = IN_W + 1,
    parameter int unsigned ET      = 4,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    approx_adder_if.master         bus,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic                   timeout,
    output logic [OUT_W-1:0]       max_err,
    output logic [CNT_W-1:0]       err_count,
    output logic [CNT_W-1:0]       viol_count,
    output logic [CNT_W+OUT_W-1:0] sum_err
);
    localparam int unsigned IDX_W  = 2 * IN_W;
    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);
    localparam int unsigned DIFF_W = OUT_W + 1;
    localparam int unsigned SUM_W  = CNT_W + OUT_W;
    localparam int unsigned CNT1_W = CNT_W + 1;
    localparam int unsigned SUM1_W = SUM_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = '1;

    typedef enum logic [1:0] {IDLE, RUN, ACC, DONE} state_t;

    state_t            state, state_next;
    logic [IDX_W-1:0]  index, index_next;
    logic [WAIT_W-1:0] wait_cnt, wait_next;
    logic [OUT_W-1:0]  approx, approx_next;
    logic              timeout_next, pass_next;
    logic [OUT_W-1:0]  max_next;
    logic [CNT_W-1:0]  errc_next, viol_next;
    logic [SUM_W-1:0]  sum_next;

    logic [OUT_W-1:0]  exact_c;
    logic [DIFF_W-1:0] diff_c;
    logic [OUT_W-1:0]  err_c;
    logic [CNT1_W-1:0] errc_inc_c, viol_inc_c;
    logic [SUM1_W-1:0] sum_inc_c;
    logic [CNT_W-1:0]  errc_sat_c, viol_sat_c;
    logic [SUM_W-1:0]  sum_sat_c;

    // Error of the captured response and saturating statistic updates
    always_comb begin
        exact_c = OUT_W'(index[IN_W-1:0]) + OUT_W'(index[IDX_W-1:IN_W]);
        if (exact_c >= approx) diff_c = DIFF_W'(exact_c) - DIFF_W'(approx);
        else                   diff_c = DIFF_W'(approx) - DIFF_W'(exact_c);
        err_c      = diff_c[OUT_W-1:0];
        errc_inc_c = CNT1_W'(err_count) + CNT1_W'(err_c != '0);
        viol_inc_c = CNT1_W'(viol_count) + CNT1_W'(32'(err_c) > ET);
        sum_inc_c  = SUM1_W'(sum_err) + SUM1_W'(err_c);
        errc_sat_c = errc_inc_c[CNT_W] ? '1 : errc_inc_c[CNT_W-1:0];
        viol_sat_c = viol_inc_c[CNT_W] ? '1 : viol_inc_c[CNT_W-1:0];
        sum_sat_c  = sum_inc_c[SUM_W]  ? '1 : sum_inc_c[SUM_W-1:0];
    end

    // Next-state and next-statistics logic
    always_comb begin
        state_next   = state;
        index_next   = index;
        wait_next    = wait_cnt;
        approx_next  = approx;
        timeout_next = timeout;
        pass_next    = pass;
        max_next     = max_err;
        errc_next    = err_count;
        viol_next    = viol_count;
        sum_next     = sum_err;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    index_next   = '0;
                    wait_next    = '0;
                    timeout_next = 1'b0;
                    pass_next    = 1'b0;
                    max_next     = '0;
                    errc_next    = '0;
                    viol_next    = '0;
                    sum_next     = '0;
                    state_next   = RUN;
                end
            end
            RUN: begin
                if (bus.resp_valid) begin
                    approx_next = bus.resp_data;
                    state_next  = ACC;
                end else begin
                    wait_next = wait_cnt + WAIT_W'(1);
                    if (wait_next == WAIT_W'(TIMEOUT)) begin
                        timeout_next = 1'b1;
                        pass_next    = 1'b0;
                        state_next   = DONE;
                    end
                end
            end
            ACC: begin
                max_next  = (err_c > max_err) ? err_c : max_err;
                errc_next = errc_sat_c;
                viol_next = viol_sat_c;
                sum_next  = sum_sat_c;
                if (index == LAST_IDX) begin
                    pass_next  = (viol_sat_c == '0) && !timeout;
                    state_next = DONE;
                end else begin
                    index_next = index + IDX_W'(1);
                    wait_next  = '0;
                    state_next = RUN;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, statistics and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            index          <= '0;
            wait_cnt       <= '0;
            approx         <= '0;
            timeout        <= 1'b0;
            pass           <= 1'b0;
            max_err        <= '0;
            err_count      <= '0;
            viol_count     <= '0;
            sum_err        <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            bus.stim_valid <= 1'b0;
        end else begin
            state          <= state_next;
            index          <= index_next;
            wait_cnt       <= wait_next;
            approx         <= approx_next;
            timeout        <= timeout_next;
            pass           <= pass_next;
            max_err        <= max_next;
            err_count      <= errc_next;
            viol_count     <= viol_next;
            sum_err        <= sum_next;
            busy           <= (state_next == RUN) || (state_next == ACC);
            done           <= (state_next == DONE);
            bus.stim_valid <= (state_next == RUN);
        end
    end

    assign bus.stim_data = index;

endmodule

// File: tb/tb_approx_adder_error_monitor.sv
// Randomized sweeps of the error monitor against a table-driven responder and a
// whole-sweep statistics model computed directly from the response table.
module tb_approx_adder_error_monitor;
    localparam int unsigned IN_W    = 2;
    localparam int unsigned OUT_W   = 3;
    localparam int unsigned ET      = 4;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned TIMEOUT = 16;
    localparam int          NVEC    = 1 << (2 * IN_W);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic busy, done, pass, timeout;
    logic [OUT_W-1:0]       max_err;
    logic [CNT_W-1:0]       err_count, viol_count;
    logic [CNT_W+OUT_W-1:0] sum_err;

    approx_adder_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    approx_adder_error_monitor #(
        .IN_W(IN_W), .OUT_W(OUT_W), .ET(ET), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bus(bus),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .max_err(max_err), .err_count(err_count), .viol_count(viol_count), .sum_err(sum_err)
    );

    always #5 clk = ~clk;

    logic [OUT_W-1:0] tbl [NVEC];
    int  resp_delay = 0;
    bit  never = 1'b0;
    bit  stray = 1'b0;
    int  hold_cnt;
    int  hs_cnt;
    int  n_chk = 0;
    int  n_fail = 0;
    int  e_max, e_cnt, e_viol, e_sum;
    bit  e_pass;

    // Responder: answers tbl[operands] after resp_delay cycles; stray pulses while stim_valid is low
    always @(posedge clk or negedge rst_n)
        if (!rst_n)               hold_cnt <= 0;
        else if (!bus.stim_valid) hold_cnt <= 0;
        else                      hold_cnt <= hold_cnt + 1;

    always_comb begin
        bus.resp_valid = 1'b0;
        bus.resp_data  = '0;
        if (bus.stim_valid) begin
            if (!never && hold_cnt >= resp_delay) begin
                bus.resp_valid = 1'b1;
                bus.resp_data  = tbl[bus.stim_data];
            end
        end else if (stray) begin
            bus.resp_valid = 1'b1;
            bus.resp_data  = '1;
        end
    end

    // Accepted responses in the current sweep; also the operand index the DUT must present
    always @(posedge clk or negedge rst_n)
        if (!rst_n)                             hs_cnt <= 0;
        else if (start && !busy)                hs_cnt <= 0;
        else if (bus.stim_valid && bus.resp_valid) hs_cnt <= hs_cnt + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected statistics of a full sweep, straight from the response table
    task automatic model();
        e_max = 0; e_cnt = 0; e_viol = 0; e_sum = 0;
        for (int v = 0; v < NVEC; v++) begin
            int a, b, d;
            a = v % (1 << IN_W);
            b = v / (1 << IN_W);
            d = (a + b) - int'(tbl[v]);
            if (d < 0) d = -d;
            if (d > e_max) e_max = d;
            if (d != 0) e_cnt++;
            if (d > int'(ET)) e_viol++;
            e_sum += d;
        end
        e_pass = (e_viol == 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stim_valid"}, bus.stim_valid, 0);
        check({tag, "_stim_data"}, bus.stim_data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pass"}, pass, 0);
        check({tag, "_timeout"}, timeout, 0);
        check({tag, "_stats"}, {max_err, err_count, viol_count, sum_err}, 0);
    endtask

    // One sweep from IDLE/DONE; per-cycle order checks; optional start pulse mid-run
    task automatic sweep(input int budget, input int pulse_at, output int cycles);
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        cycles = 0;
        while (!done && cycles < budget) begin
            @(posedge clk); cycles++; #1;
            start = (cycles == pulse_at);
            if (bus.stim_valid) begin
                check("stim_order", bus.stim_data, hs_cnt);
                check("run_status", {busy, done}, 2'b10);
            end
        end
        start = 1'b0;
        if (!done) check("done_reached", 0, 1);
    endtask

    task automatic check_stats(input string tag);
        model();
        check({tag, "_max_err"}, max_err, e_max);
        check({tag, "_err_count"}, err_count, e_cnt);
        check({tag, "_viol_count"}, viol_count, e_viol);
        check({tag, "_sum_err"}, sum_err, e_sum);
        check({tag, "_pass"}, pass, e_pass);
        check({tag, "_flags"}, {done, busy, timeout, bus.stim_valid}, 4'b1000);
        check({tag, "_updates"}, hs_cnt, NVEC);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int ex;
        for (int v = 0; v < NVEC; v++) tbl[v] = '0;
        repeat (3) @(posedge clk);
        #1 check_all_zero("reset");
        @(negedge clk); rst_n = 1'b1;

        // Exact responder
        for (int v = 0; v < NVEC; v++) tbl[v] = OUT_W'(v % 4 + v / 4);
        sweep(200, 0, cyc);
        check("exact_cycles", cyc, 32);
        check("exact_lit", {max_err, err_count, viol_count, sum_err, pass}, {3'd0, 16'd0, 16'd0, 19'd0, 1'b1});
        check_stats("exact");

        // Constant-0 responder
        for (int v = 0; v < NVEC; v++) tbl[v] = '0;
        sweep(200, 0, cyc);
        check("zero_max_err", max_err, 6);
        check("zero_err_count", err_count, 15);
        check("zero_viol_count", viol_count, 3);
        check("zero_sum_err", sum_err, 48);
        check("zero_pass", pass, 0);
        check_stats("zero");

        // ET-bounded approximate responder
        for (int v = 0; v < NVEC; v++) begin
            ex = v % 4 + v / 4 + int'($urandom_range(0, 8)) - 4;
            if (ex < 0) ex = 0;
            if (ex > 7) ex = 7;
            tbl[v] = OUT_W'(ex);
        end
        sweep(200, 0, cyc);
        check("etb_bounded", (max_err <= 3'(ET)) && (viol_count == 0) && pass, 1);
        check_stats("etb");

        // 3-cycle responder with stray resp_valid outside RUN
        resp_delay = 3; stray = 1'b1;
        sweep(400, 0, cyc);
        check("delay3_cycles", cyc, NVEC * 5);
        check_stats("delay3");

        // Restart from DONE while stray resp_valid is high; start pulse during RUN ignored
        resp_delay = 0;
        for (int v = 0; v < NVEC; v++) tbl[v] = OUT_W'($urandom_range(0, 7));
        sweep(200, 9, cyc);
        check("pulse_cycles", cyc, 32);
        check_stats("pulse");
        stray = 1'b0;

        // No responder: timeout
        never = 1'b1;
        sweep(100, 0, cyc);
        check("to_cycles", cyc, TIMEOUT);
        check("to_flags", {done, busy, timeout, pass, bus.stim_valid}, 5'b10100);
        check("to_stim_data", bus.stim_data, 0);
        check("to_stats", {max_err, err_count, viol_count, sum_err}, 0);
        never = 1'b0;

        // Reset while vector 7 is presented, then a fresh sweep
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        cyc = 0;
        while (!(bus.stim_valid && bus.stim_data == 4'd7) && cyc < 100) begin
            @(posedge clk); cyc++; #1;
        end
        check("reached_vec7", bus.stim_data, 7);
        #2 rst_n = 1'b0;
        #1 check_all_zero("midrst");
        @(posedge clk); #1 check_all_zero("midrst_hold");
        @(negedge clk); rst_n = 1'b1;
        sweep(200, 0, cyc);
        check("rerun_cycles", cyc, 32);
        check_stats("rerun");

        // Randomized sweeps
        for (int s = 0; s < 4; s++) begin
            resp_delay = int'($urandom_range(0, 5));
            stray = 1'(($urandom_range(0, 1)));
            for (int v = 0; v < NVEC; v++) tbl[v] = OUT_W'($urandom_range(0, 7));
            sweep(600, 0, cyc);
            check("rand_cycles", cyc, NVEC * (resp_delay + 2));
            check_stats("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/approx_adder_error_monitor.md
Name: approx_adder_error_monitor

Overview:
- Sequential evaluation harness for the XPAT-generated approximate adders.
- Acts as the stimulus/checking end of the approximate-adder interface. It drives every operand pair exhaustively into an approximate adder and collects the adder's sum.
- For each vector it compares the collected sum with the exact sum and accumulates error statistics.
- It reports pass/fail against the error threshold used at synthesis time. Used in hardware-in-the-loop validation of et-bounded netlists.

Parameters:
- IN_W, 2, width of each operand (adder has 2*IN_W inputs).
- OUT_W, IN_W+1, width of the approximate sum.
- ET, 4, error threshold; any |exact-approx| > ET is a violation.
- CNT_W, 16, width of the error and violation counters (saturating).
- TIMEOUT, 16, maximum cycles to wait for resp_valid per vector.

Ports:
- clk  input  1  single clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse: clear statistics and begin a sweep (honoured only in IDLE or DONE).
- stim_valid  output  1  high while a vector is presented and awaiting response.
- stim_data  output  2*IN_W  operands. Bits [IN_W-1:0] = a drives in0..in(IN_W-1). Bits [2*IN_W-1:IN_W] = b drives the next IN_W inputs.
- resp_valid  input  1  approximate sum valid; sampled only in RUN.
- resp_data  input  OUT_W  approximate sum, bit0 = out0 (LSB).
- busy  output  1  high in RUN/ACC.
- done  output  1  high in DONE until next start.
- pass  output  1  valid with done: 1 iff viol_count==0 and no timeout.
- timeout  output  1  sticky: a vector exceeded TIMEOUT wait cycles.
- max_err  output  OUT_W  largest |exact-approx| seen.
- err_count  output  CNT_W  vectors with nonzero error.
- viol_count  output  CNT_W  vectors with error > ET.
- sum_err  output  CNT_W+OUT_W  accumulated absolute error (mean = sum_err / 2^(2*IN_W)).

Behaviour:
- Reset (async, rst_n=0): state IDLE. stim_valid, busy, done, pass and timeout = 0. stim_data, max_err, err_count, viol_count and sum_err = 0. Internal vector index and wait counter = 0.
- Reset mid-sweep aborts immediately; no partial result is retained.
- FSM states: IDLE, RUN, ACC, DONE.
- IDLE/DONE + start=1: clear all statistics, timeout and pass; set index=0; go to RUN. start in RUN/ACC is ignored.
- RUN:
  - stim_valid=1, stim_data=index.
  - If resp_valid=1: register resp_data, go to ACC.
  - Else increment the wait counter. When the counter reaches TIMEOUT, set timeout=1, pass=0, go to DONE.
- ACC (1 cycle, stim_valid=0):
  - exact = a+b computed in OUT_W bits (no overflow).
  - err = |exact - approx|, computed in OUT_W+1 bits, then truncated to OUT_W.
  - Update statistics:
    - max_err = max(max_err, err).
    - err_count += (err!=0).
    - viol_count += (err>ET).
    - sum_err += err.
  - All counters saturate at all-ones; they never wrap.
  - If index == 2^(2*IN_W)-1, go to DONE with pass = (viol_count_next==0). Otherwise index+1, clear the wait counter, go to RUN.
- Throughput is one vector per 2 cycles when resp_valid is already high in RUN.
- For IN_W=2 with an immediate responder, done rises on the 32nd rising edge after the edge that samples start.
- resp_valid outside RUN is ignored; at most one response is accepted per vector.
- DONE: statistics and pass are held stable; done=1 until start.
- Index wrap: index never wraps. Sweep termination is decided by the last-index compare, not by overflow.
- Simultaneous start and resp_valid in DONE: start wins and resp_valid is ignored.

Test Plan:
- Exact adder responder (resp_data=a+b, resp_valid tied 1), ET=4 -> done after 32 cycles; max_err=0, err_count=0, viol_count=0, sum_err=0, pass=1.
- Constant-0 responder -> max_err=6, err_count=15, viol_count=3 (sums 5,5,6), sum_err=48, pass=0.
- Responder from the ET=4 approximate adder netlist -> max_err<=4, viol_count=0, pass=1; stim_data sequence 0..15 in order.
- resp_valid held 0, TIMEOUT=16 -> after 16 RUN cycles timeout=1, done=1, pass=0, stim_data=0.
- Responder with 3-cycle delay per vector and stray resp_valid during ACC -> stray pulses ignored, exactly 16 updates, statistics match the zero-delay run.
- rst_n pulled low at vector 7, then start again -> all outputs 0 during reset; new sweep gives identical results to an uninterrupted run; start pulsed during RUN has no effect.
